// File: rtl/hazard_control_if.sv
// hazard_control_if
//   Bundle between the WISC-SP20 pipeline datapath and the hazard sequencer.
//   master : datapath side, drives the hazard inputs and receives the
//            stage-register controls.
//   slave  : hazard_control side.
//   Signals:
//     rs_d, rt_d, use_rs_d, use_rt_d  decode-stage source operands
//     rd_e, reg_write_e, mem_read_e   execute-stage destination / load info
//     br_taken_e                      branch/jump taken, resolved in EX
//     dmem_busy_m, halt_m             MEM-stage memory busy / HALT present
//     pc_en, ifid_en, idex_en, exmem_en         stage load enables
//     ifid_flush, idex_flush, memwb_flush       stage NOP inserts
//     halted, err                     sticky status flags
interface hazard_control_if;
    logic [2:0] rs_d;
    logic [2:0] rt_d;
    logic       use_rs_d;
    logic       use_rt_d;
    logic [2:0] rd_e;
    logic       reg_write_e;
    logic       mem_read_e;
    logic       br_taken_e;
    logic       dmem_busy_m;
    logic       halt_m;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_flush;
    logic       exmem_en;
    logic       memwb_flush;
    logic       halted;
    logic       err;

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, rd_e, reg_write_e,
               mem_read_e, br_taken_e, dmem_busy_m, halt_m,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, halted, err
    );

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, rd_e, reg_write_e,
               mem_read_e, br_taken_e, dmem_busy_m, halt_m,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, halted, err
    );
endinterface

// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline sequencer for the 5-stage WISC-SP20 core. Inserts the single
//   load-use bubble, flushes wrong-path instructions on a taken branch/jump
//   in EX, freezes the pipe while data memory is busy, and latches HALT.
//   Ports:
//     clk    core clock, rising edge
//     rst_n  asynchronous active-low reset
//     hc     hazard_control_if.slave (hazard inputs, stage enables/flushes,
//            halted and err status)
//     stall_cnt, flush_cnt  performance counters (HAZARD_PERF_EN only)
//   Parameter:
//     MAX_WAIT  consecutive dmem busy cycles before err sets (4-bit count)
//   Build option:
//     HAZARD_PERF_EN  adds the 16-bit wrapping stall/flush counters.
module hazard_control #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_control_if.slave  hc
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, LDSTALL, DWAIT, HALT} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait_cnt;
    logic       r_err;

    logic w_ldhaz;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
    logic w_ifid_flush, w_idex_flush, w_memwb_flush;

    always_comb begin
        w_ldhaz = hc.mem_read_e & hc.reg_write_e &
                  ((hc.use_rs_d & (hc.rs_d == hc.rd_e)) |
                   (hc.use_rt_d & (hc.rt_d == hc.rd_e)));

        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_memwb_flush = 1'b0;
        w_next        = r_state;

        if (!rst_n) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_memwb_flush = 1'b1;
            w_next        = RUN;
        end else begin
            unique case (r_state)
                RUN, LDSTALL: begin
                    w_next = RUN;
                    if (hc.halt_m) begin
                        // HALT itself retires into MEM/WB; everything else holds.
                        w_pc_en    = 1'b0;
                        w_ifid_en  = 1'b0;
                        w_idex_en  = 1'b0;
                        w_exmem_en = 1'b0;
                        w_next     = HALT;
                    end else if (hc.dmem_busy_m) begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_en     = 1'b0;
                        w_exmem_en    = 1'b0;
                        w_memwb_flush = 1'b1;
                        w_next        = DWAIT;
                    end else if (r_state == RUN) begin
                        // The bubble cycle only honours halt/busy; the load
                        // result now reaches the consumer via MEM->EX forward.
                        if (hc.br_taken_e) begin
                            w_ifid_flush = 1'b1;
                            w_idex_flush = 1'b1;
                        end else if (w_ldhaz) begin
                            w_pc_en      = 1'b0;
                            w_ifid_en    = 1'b0;
                            w_idex_flush = 1'b1;
                            w_next       = LDSTALL;
                        end
                    end
                end
                DWAIT: begin
                    if (hc.dmem_busy_m) begin
                        // Halt in MEM is deliberately ignored while frozen.
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_en     = 1'b0;
                        w_exmem_en    = 1'b0;
                        w_memwb_flush = 1'b1;
                    end else begin
                        w_next = RUN;
                        if (hc.br_taken_e) begin
                            w_ifid_flush = 1'b1;
                            w_idex_flush = 1'b1;
                        end else if (w_ldhaz) begin
                            w_pc_en      = 1'b0;
                            w_ifid_en    = 1'b0;
                            w_idex_flush = 1'b1;
                            w_next       = LDSTALL;
                        end
                    end
                end
                HALT: begin
                    w_pc_en       = 1'b0;
                    w_ifid_en     = 1'b0;
                    w_idex_en     = 1'b0;
                    w_exmem_en    = 1'b0;
                    w_memwb_flush = 1'b1;
                end
                default: w_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != DWAIT && w_next == DWAIT) begin
                r_wait_cnt <= 4'd1;
            end else if (r_state == DWAIT && hc.dmem_busy_m) begin
                if (r_wait_cnt != 4'(MAX_WAIT)) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                // err rises on the same edge the count reaches MAX_WAIT, so
                // it is visible after MAX_WAIT consecutive busy cycles.
                if (r_wait_cnt >= 4'(MAX_WAIT - 1)) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == DWAIT) begin
                r_wait_cnt <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!w_pc_en && r_state != HALT) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (w_ifid_flush) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

    assign hc.pc_en       = w_pc_en;
    assign hc.ifid_en     = w_ifid_en;
    assign hc.idex_en     = w_idex_en;
    assign hc.exmem_en    = w_exmem_en;
    assign hc.ifid_flush  = w_ifid_flush;
    assign hc.idex_flush  = w_idex_flush;
    assign hc.memwb_flush = w_memwb_flush;
    assign hc.halted      = (r_state == HALT);
    assign hc.err         = r_err;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    // Output vector order:
    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted, err}
    localparam logic [8:0] V_RUN   = 9'b110101000;
    localparam logic [8:0] V_RUNE  = 9'b110101001;
    localparam logic [8:0] V_RST   = 9'b001010100;
    localparam logic [8:0] V_LDS   = 9'b000111000;
    localparam logic [8:0] V_BR    = 9'b111111000;
    localparam logic [8:0] V_FRZ   = 9'b000000100;
    localparam logic [8:0] V_FRZE  = 9'b000000101;
    localparam logic [8:0] V_HLTIN = 9'b000000000;
    localparam logic [8:0] V_HALT  = 9'b000000110;

    logic clk;
    logic rst_n;

    hazard_control_if hc ();

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    hazard_control #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hc    (hc)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] obs;
    assign obs = {hc.pc_en, hc.ifid_en, hc.ifid_flush, hc.idex_en, hc.idex_flush,
                  hc.exmem_en, hc.memwb_flush, hc.halted, hc.err};

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic [2:0] rd,
                       input logic rw, input logic mr, input logic br,
                       input logic busy, input logic halt);
        hc.rs_d        = rs;
        hc.rt_d        = rt;
        hc.use_rs_d    = urs;
        hc.use_rt_d    = urt;
        hc.rd_e        = rd;
        hc.reg_write_e = rw;
        hc.mem_read_e  = mr;
        hc.br_taken_e  = br;
        hc.dmem_busy_m = busy;
        hc.halt_m      = halt;
    endtask

    task automatic idle();
        drv(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ld R3 in EX, add R1,R3,R2 in ID
    task automatic ld_use();
        drv(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One cycle: expectation queued with the stimulus, popped at the sample point.
    task automatic cyc(input string tag, input logic [8:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e = sb.pop_front();
        check(e.tag, {23'd0, obs}, {23'd0, e.exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        cyc("reset", V_RST);
        rst_n = 1'b1;
        cyc("run_after_reset", V_RUN);

        // Load-use, consumer via Rt
        ld_use();
        cyc("ldhaz_rt", V_LDS);
        cyc("ldstall_one_cycle", V_RUN);
        idle();
        cyc("ld_back_run", V_RUN);
        // Same, Rt not read and Rs mismatched: no stall
        drv(3'd1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("ld_no_use_rt", V_RUN);
        // Consumer via Rs
        drv(3'd3, 3'd2, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("ldhaz_rs", V_LDS);
        idle();
        cyc("ldhaz_rs_done", V_RUN);
        // Load without register write is not a hazard
        drv(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("ld_no_wr", V_RUN);

        // Branch together with load-use: branch wins, no bubble
        drv(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("br_and_ld", V_BR);
        idle();
        cyc("br_after", V_RUN);

        // Data memory busy for 3 cycles
        hc.dmem_busy_m = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("dwait3_%0d", i), V_FRZ);
        hc.dmem_busy_m = 1'b0;
        cyc("dwait3_resume", V_RUN);
        cyc("dwait3_after", V_RUN);

        // Busy beats a branch; branch honoured on the DWAIT exit cycle
        drv(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("busy_over_br", V_FRZ);
        drv(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("dwait_exit_br", V_BR);
        idle();
        cyc("dwait_exit_br_after", V_RUN);

        // Busy for 20 cycles: err visible after 15 busy cycles and sticky
        hc.dmem_busy_m = 1'b1;
        for (int i = 1; i <= 20; i++)
            cyc($sformatf("busy20_c%0d", i), (i <= 15) ? V_FRZ : V_FRZE);

        // Asynchronous reset mid-DWAIT
        rst_n = 1'b0;
        cyc("reset_mid_dwait", V_RST);
        rst_n = 1'b1;
        idle();
        cyc("reset_mid_dwait_release", V_RUN);

        // Halt has priority over busy in RUN
        drv(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("halt_over_busy", V_HLTIN);
        idle();
        cyc("halted_a", V_HALT);
        rst_n = 1'b0;
        cyc("reset_in_halt", V_RST);
        rst_n = 1'b1;
        cyc("halt_reset_release", V_RUN);

        // Halt arriving while frozen waits for busy to drop
        hc.dmem_busy_m = 1'b1;
        cyc("frz_enter", V_FRZ);
        hc.halt_m = 1'b1;
        cyc("frz_halt_ignored", V_FRZ);
        hc.dmem_busy_m = 1'b0;
        cyc("frz_exit_with_halt", V_RUN);
        cyc("halt_taken", V_HLTIN);
        hc.halt_m = 1'b0;
        cyc("halted_b", V_HALT);
        drv(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("halted_sticky", V_HALT);
        idle();
        cyc("halted_sticky2", V_HALT);
        rst_n = 1'b0;
        cyc("reset_halt_b", V_RST);
        rst_n = 1'b1;
        cyc("run_final", V_RUN);

`ifdef HAZARD_PERF_EN
        // Counters were cleared by the reset above
        ld_use();
        cyc("perf_ld1", V_LDS);
        idle();
        cyc("perf_ld1_done", V_RUN);
        ld_use();
        cyc("perf_ld2", V_LDS);
        idle();
        cyc("perf_ld2_done", V_RUN);
        hc.br_taken_e = 1'b1;
        cyc("perf_br", V_BR);
        hc.br_taken_e = 1'b0;
        cyc("perf_idle", V_RUN);
        check("stall_cnt", {16'd0, stall_cnt}, 32'd2);
        check("flush_cnt", {16'd0, flush_cnt}, 32'd1);
        force dut.stall_cnt = 16'hFFFF;
        #1;
        release dut.stall_cnt;
        ld_use();
        cyc("perf_wrap_ld", V_LDS);
        idle();
        check("stall_cnt_wrap", {16'd0, stall_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
